// File: rtl/jpeg_codec_pkg.sv
// Tables and constants shared by the JPEG encoder and decoder stages:
// zigzag-to-raster map, standard luma/chroma quantization tables, channel codes.
package jpeg_codec_pkg;

   localparam int PIXEL_COUNT = 64;

   typedef enum logic [1:0] {
      CHAN_Y  = 2'd0,
      CHAN_CB = 2'd1,
      CHAN_CR = 2'd2
   } chan_e;

   // ZZ_MAP[k] is the raster index of the k-th coefficient in zigzag order.
   localparam logic [5:0] ZZ_MAP [PIXEL_COUNT] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   localparam logic [7:0] LUMA_Q [PIXEL_COUNT] = '{
      8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
      8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
      8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
      8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
      8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
      8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
      8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
      8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
   };

   localparam logic [7:0] CHROMA_Q [PIXEL_COUNT] = '{
      8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
   };

endpackage

// File: rtl/jpeg_dezigzag_dequant_if.sv
// Coefficient input stream and block output stream of jpeg_dezigzag_dequant.
interface jpeg_dezigzag_dequant_if
   import jpeg_codec_pkg::*;
#(
   parameter int DATA_WIDTH = 32
);
   logic                                s_valid;
   logic                                s_ready;
   logic signed [DATA_WIDTH-1:0]        s_coef;
   logic [1:0]                          s_chan;
   logic                                s_last;
   logic                                m_valid;
   logic                                m_ready;
   logic [DATA_WIDTH*PIXEL_COUNT-1:0]   m_block;
   logic [1:0]                          m_chan;
   logic                                err;

   modport slave (
      input  s_valid, s_coef, s_chan, s_last, m_ready,
      output s_ready, m_valid, m_block, m_chan, err
   );

   modport master (
      output s_valid, s_coef, s_chan, s_last, m_ready,
      input  s_ready, m_valid, m_block, m_chan, err
   );
endinterface

// File: rtl/jpeg_dequant_mult.sv
// Signed coefficient times unsigned 8-bit table entry, saturated to DATA_WIDTH.
// Only present when JPEG_DEQUANT_EN is defined.
`ifdef JPEG_DEQUANT_EN
module jpeg_dequant_mult #(
   parameter int DATA_WIDTH = 32
) (
   input  logic signed [DATA_WIDTH-1:0] i_coef,
   input  logic        [7:0]            i_q,
   output logic signed [DATA_WIDTH-1:0] o_value
);
   localparam int PW = DATA_WIDTH + 8;

   function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] max_v;
      logic signed [PW-1:0] min_v;
      max_v = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
      min_v = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
      if (p > max_v) begin
         sat = max_v[DATA_WIDTH-1:0];
      end else if (p < min_v) begin
         sat = min_v[DATA_WIDTH-1:0];
      end else begin
         sat = p[DATA_WIDTH-1:0];
      end
   endfunction

   logic signed [PW-1:0] w_coef_ext;
   logic signed [PW-1:0] w_q_ext;
   logic signed [PW-1:0] w_prod;

   // |coef| <= 2^(DW-1) and q <= 255, so the product always fits in DW+8 signed bits.
   assign w_coef_ext = PW'(i_coef);
   assign w_q_ext    = {{(PW-8){1'b0}}, i_q};
   assign w_prod     = w_coef_ext * w_q_ext;
   assign o_value    = sat(w_prod);
endmodule
`endif

// File: rtl/jpeg_dezigzag_dequant.sv
// Inverse zigzag (and dequantization when JPEG_DEQUANT_EN is defined) into two
// ping-pong banks; each completed block is presented as one raster-order vector.
module jpeg_dezigzag_dequant
   import jpeg_codec_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   jpeg_dezigzag_dequant_if.slave   bus
);
   logic [5:0]                   r_cnt;
   logic                         r_wr_bank;
   logic                         r_rd_bank;
   logic [1:0]                   r_full;
   logic                         r_err;
   logic [1:0]                   r_chan [2];
   logic signed [DATA_WIDTH-1:0] r_bank [2][PIXEL_COUNT];

   logic                         w_accept;
   logic                         w_out_hs;
   logic                         w_last_beat;
   logic [5:0]                   w_raster;
   logic signed [DATA_WIDTH-1:0] w_value;

   assign w_accept    = bus.s_valid & ~r_full[r_wr_bank];
   assign w_out_hs    = bus.m_ready & r_full[r_rd_bank];
   assign w_last_beat = (r_cnt == 6'd63);
   assign w_raster    = ZZ_MAP[r_cnt];

`ifdef JPEG_DEQUANT_EN
   logic [1:0] w_chan_cur;
   logic [7:0] w_q;

   // The channel register is written on beat 0, so that beat uses s_chan directly.
   assign w_chan_cur = (r_cnt == 6'd0) ? bus.s_chan : r_chan[r_wr_bank];

   always_comb begin
      if (w_chan_cur == CHAN_Y) begin
         w_q = LUMA_Q[w_raster];
      end else begin
         w_q = CHROMA_Q[w_raster];
      end
   end

   jpeg_dequant_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
      .i_coef  (bus.s_coef),
      .i_q     (w_q),
      .o_value (w_value)
   );
`else
   assign w_value = bus.s_coef;
`endif

   assign bus.s_ready = ~r_full[r_wr_bank];
   assign bus.m_valid = r_full[r_rd_bank];
   assign bus.m_chan  = r_chan[r_rd_bank];
   assign bus.err     = r_err;

   always_comb begin
      bus.m_block = '0;
      for (int i = 0; i < PIXEL_COUNT; i++) begin
         bus.m_block[i*DATA_WIDTH +: DATA_WIDTH] = r_bank[r_rd_bank][i];
      end
   end

   // Write counter, bank ownership, full flags and the sticky protocol error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= 6'd0;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_full    <= 2'b00;
         r_err     <= 1'b0;
         r_chan[0] <= 2'd0;
         r_chan[1] <= 2'd0;
      end else begin
         if (w_accept) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd0) begin
               r_chan[r_wr_bank] <= bus.s_chan;
            end
            if (bus.s_last != w_last_beat) begin
               r_err <= 1'b1;
            end
            if (w_last_beat) begin
               r_full[r_wr_bank] <= 1'b1;
               r_wr_bank         <= ~r_wr_bank;
            end
         end
         // Accept needs the write bank empty and handshake needs the read bank full,
         // so both updates always target different banks.
         if (w_out_hs) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < PIXEL_COUNT; i++) begin
               r_bank[b][i] <= '0;
            end
         end
      end else if (w_accept) begin
         r_bank[r_wr_bank][w_raster] <= w_value;
      end
   end
endmodule
